vrf_arbiter: RTL and testbench
==============================

Name: vrf_arbiter

Overview:
- Shares the single-port vector register file wrapper between NumReq requesters, e.g. the vector execute sequencer (req 0) and the vector load/store unit (req 1).
- Grants whole vector operations, from the wrapper's request through to its vector_done pulse, using round-robin priority.
- Forwards the owner's command fields and write-element stream to the wrapper.
- Broadcasts read elements and routes the done pulse back to the owner only.

Parameters:
- NumReq, 2, number of requesters (2..4).
- AddrWidth, 5, VRF register address width.
- ELEN, 32, element width in bits.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- req_i  in  NumReq  per-requester operation request; hold high until done_o.
- we_i  in  NumReq  per-requester write-back enable.
- raddr_a_i  in  NumReq*AddrWidth  flattened vs1 base address; requester k occupies slice k.
- raddr_b_i  in  NumReq*AddrWidth  flattened vs2 base address.
- waddr_i  in  NumReq*AddrWidth  flattened vd/vs3 base address.
- num_operands_i  in  NumReq*2  flattened operand count (0..3).
- lmul_i  in  NumReq*3  flattened vcve2_pkg::vlmul_e.
- wdata_i  in  NumReq*ELEN  flattened write element streams.
- gnt_o  out  NumReq  one-hot owner indication.
- done_o  out  NumReq  one-cycle done pulse, to the owner only.
- rdata_a_o, rdata_b_o, rdata_c_o  out  ELEN each  broadcast read elements; valid only for the owner.
- vrf_req_o, vrf_we_o  out  1 each  to the wrapper's req_i and we_i.
- vrf_raddr_a_o, vrf_raddr_b_o, vrf_waddr_o  out  AddrWidth each  to the wrapper.
- vrf_num_operands_o  out  2  to the wrapper.
- vrf_lmul_o  out  3  to the wrapper.
- vrf_wdata_o  out  ELEN  to the wrapper.
- vrf_rdata_a_i, vrf_rdata_b_i, vrf_rdata_c_i  in  ELEN each  from the wrapper.
- vrf_done_i  in  1  from the wrapper's vector_done_o.

Behaviour:
- Reset values: state=ARB_IDLE, owner=0, gnt_o=0, done_o=0, vrf_req_o=0, rr_ptr=0 (requester 0 has top priority).
- Reset taken mid-operation clears everything immediately. The wrapper shares rst_ni, so no partial state survives.
- FSM state ARB_IDLE: vrf_req_o=0.
  - If any req_i bit is high, pick the first set bit scanning from rr_ptr upward, modulo NumReq.
  - Register owner, set gnt_o to one-hot(owner), go to ARB_BUSY.
- FSM state ARB_BUSY: vrf_req_o=1.
  - All vrf_* command outputs are muxed from the owner's slice: we, raddr_a, raddr_b, waddr, num_operands, lmul, wdata.
  - On vrf_done_i=1: done_o[owner]=1 in the same cycle (combinational), rr_ptr <= owner+1 mod NumReq, gnt_o <= 0, next state ARB_IDLE.
  - Otherwise stay in ARB_BUSY.
- Outside ARB_BUSY, command outputs are driven to 0.
- Latency:
  - req_i rising in ARB_IDLE at cycle n gives gnt_o and vrf_req_o high at n+1.
  - vrf_done_i at cycle m gives ARB_IDLE at m+1; the earliest next grant is at m+2.
  - This bubble guarantees the wrapper sees req low for at least one cycle in its own idle state.
- Handshake rules:
  - The owner must hold its fields stable from grant until done_o.
  - Dropping req_i mid-operation is ignored: the grant holds until vrf_done_i, and done_o still pulses.
  - A non-owner's req_i is never acknowledged while busy.
- Boundary conditions:
  - vrf_done_i in ARB_IDLE is spurious: ignore it, done_o stays 0.
  - Single requester asserting back-to-back is granted repeatedly, with one idle cycle between operations.
  - Multi-register LMUL groups: the grant is held across every intermediate register of the group. Only the final vrf_done_i releases it.
  - rr_ptr arithmetic wraps modulo NumReq; for NumReq=2 it is a 1-bit toggle.
- rdata_*_o equal vrf_rdata_*_i unconditionally. Consumers qualify them with their own gnt_o bit.

Test Plan:
- Reset, then req_i=2'b01 with lmul=VLMUL_1, num_operands=2 → gnt_o=01 next cycle, vrf_req_o=1. Drive vrf_done_i after 4 cycles → done_o=01 in that same cycle, gnt_o=00 the next.
- req_i=2'b11 simultaneously from reset → requester 0 granted first, requester 1 granted 2 cycles after its done. A third simultaneous round grants requester 0 again.
- Requester 1 finishes with requester 0 idle, then both request → requester 0 wins (rr_ptr=0 after owner=1).
- Owner 0 drops req_i mid-BUSY → gnt_o held, vrf_req_o=1 until vrf_done_i, done_o[0] pulses once.
- vrf_done_i=1 while ARB_IDLE → done_o=00, no state change. Assert rst_ni=0 during BUSY → all outputs 0 asynchronously, rr_ptr=0.
- Owner 1 with we=1, wdata=0xDEADBEEF, waddr=5, lmul=VLMUL_4 → vrf_wdata_o=0xDEADBEEF and vrf_waddr_o=5 stable through all four group passes. Requester 0's slice never reaches the vrf_* outputs.

Source files
------------

// File: rtl/vrf_arbiter.sv
// vrf_arbiter
// Shares one single-port vector register file wrapper between NumReq
// requesters. A grant covers a whole vector operation: from the wrapper
// request through to its vector_done pulse. Ownership rotates round-robin.
//
// Ports
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   req_i, we_i              per-requester request / write-back enable
//   raddr_a_i, raddr_b_i,
//   waddr_i, num_operands_i,
//   lmul_i, wdata_i          flattened per-requester command fields (slice k = requester k)
//   gnt_o                    one-hot owner indication
//   done_o                   one-cycle done pulse to the owner only
//   rdata_{a,b,c}_o          read elements broadcast to all requesters
//   vrf_*_o                  owner's command fields towards the wrapper
//   vrf_rdata_{a,b,c}_i,
//   vrf_done_i               read elements and vector_done from the wrapper
module vrf_arbiter #(
   parameter int unsigned NumReq    = 2,
   parameter int unsigned AddrWidth = 5,
   parameter int unsigned ELEN      = 32
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic [NumReq-1:0]           req_i,
   input  logic [NumReq-1:0]           we_i,
   input  logic [NumReq*AddrWidth-1:0] raddr_a_i,
   input  logic [NumReq*AddrWidth-1:0] raddr_b_i,
   input  logic [NumReq*AddrWidth-1:0] waddr_i,
   input  logic [NumReq*2-1:0]         num_operands_i,
   input  logic [NumReq*3-1:0]         lmul_i,
   input  logic [NumReq*ELEN-1:0]      wdata_i,
   output logic [NumReq-1:0]           gnt_o,
   output logic [NumReq-1:0]           done_o,
   output logic [ELEN-1:0]             rdata_a_o,
   output logic [ELEN-1:0]             rdata_b_o,
   output logic [ELEN-1:0]             rdata_c_o,
   output logic                        vrf_req_o,
   output logic                        vrf_we_o,
   output logic [AddrWidth-1:0]        vrf_raddr_a_o,
   output logic [AddrWidth-1:0]        vrf_raddr_b_o,
   output logic [AddrWidth-1:0]        vrf_waddr_o,
   output logic [1:0]                  vrf_num_operands_o,
   output logic [2:0]                  vrf_lmul_o,
   output logic [ELEN-1:0]             vrf_wdata_o,
   input  logic [ELEN-1:0]             vrf_rdata_a_i,
   input  logic [ELEN-1:0]             vrf_rdata_b_i,
   input  logic [ELEN-1:0]             vrf_rdata_c_i,
   input  logic                        vrf_done_i
);

   localparam int unsigned OwnerW = (NumReq > 1) ? $clog2(NumReq) : 1;
   // One extra bit so rr_ptr + offset can exceed NumReq-1 before wrapping.
   localparam int unsigned SumW   = OwnerW + 1;

   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_BUSY = 1'b1
   } arb_state_e;

   arb_state_e          state_reg, state_next;
   logic [OwnerW-1:0]   owner_reg, owner_next;
   logic [OwnerW-1:0]   rr_ptr_reg, rr_ptr_next;

   logic [NumReq-1:0]   one_hot_base;
   logic [NumReq-1:0]   owner_onehot;
   logic [OwnerW-1:0]   owner_inc;
   logic                pick_valid;
   logic [OwnerW-1:0]   pick_idx;
   logic                busy;

   // Unpacked views of the flattened per-requester fields.
   logic [AddrWidth-1:0] raddr_a_arr [NumReq];
   logic [AddrWidth-1:0] raddr_b_arr [NumReq];
   logic [AddrWidth-1:0] waddr_arr   [NumReq];
   logic [1:0]           nops_arr    [NumReq];
   logic [2:0]           lmul_arr    [NumReq];
   logic [ELEN-1:0]      wdata_arr   [NumReq];

   genvar gi;
   generate
      for (gi = 0; gi < NumReq; gi++) begin : g_unpack
         assign raddr_a_arr[gi] = raddr_a_i[gi*AddrWidth +: AddrWidth];
         assign raddr_b_arr[gi] = raddr_b_i[gi*AddrWidth +: AddrWidth];
         assign waddr_arr[gi]   = waddr_i[gi*AddrWidth +: AddrWidth];
         assign nops_arr[gi]    = num_operands_i[gi*2 +: 2];
         assign lmul_arr[gi]    = lmul_i[gi*3 +: 3];
         assign wdata_arr[gi]   = wdata_i[gi*ELEN +: ELEN];
      end
   endgenerate

   assign busy         = (state_reg == ARB_BUSY);
   assign one_hot_base = {{(NumReq-1){1'b0}}, 1'b1};
   assign owner_onehot = one_hot_base << owner_reg;
   assign owner_inc    = (owner_reg == OwnerW'(NumReq - 1)) ? '0 : owner_reg + OwnerW'(1);

   // Round-robin pick: scan offsets from the highest down so the last hit,
   // which is the smallest offset from rr_ptr, wins.
   always_comb begin
      logic [SumW-1:0]   sum;
      logic [OwnerW-1:0] idx;
      pick_valid = 1'b0;
      pick_idx   = '0;
      sum        = '0;
      idx        = '0;
      for (int i = int'(NumReq) - 1; i >= 0; i--) begin
         sum = {1'b0, rr_ptr_reg} + SumW'(i);
         if (sum >= SumW'(NumReq)) begin
            sum = sum - SumW'(NumReq);
         end
         idx = OwnerW'(sum);
         if ((req_i & (one_hot_base << idx)) != '0) begin
            pick_valid = 1'b1;
            pick_idx   = idx;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_reg  <= ARB_IDLE;
         owner_reg  <= '0;
         rr_ptr_reg <= '0;
      end else begin
         state_reg  <= state_next;
         owner_reg  <= owner_next;
         rr_ptr_reg <= rr_ptr_next;
      end
   end

   always_comb begin
      state_next  = state_reg;
      owner_next  = owner_reg;
      rr_ptr_next = rr_ptr_reg;
      done_o      = '0;
      case (state_reg)
         ARB_IDLE: begin
            // vrf_done_i here is spurious and deliberately ignored.
            if (pick_valid) begin
               owner_next = pick_idx;
               state_next = ARB_BUSY;
            end
         end
         ARB_BUSY: begin
            // Only the wrapper's final done releases the grant, so every
            // register of an LMUL group stays with the same owner.
            if (vrf_done_i) begin
               done_o      = owner_onehot;
               rr_ptr_next = owner_inc;
               state_next  = ARB_IDLE;
            end
         end
         default: begin
            state_next = ARB_IDLE;
         end
      endcase
   end

   // Grant follows the state register, so it drops the cycle after done and
   // the wrapper always sees one idle cycle with req low between operations.
   assign gnt_o = busy ? owner_onehot : '0;

   always_comb begin
      vrf_req_o          = 1'b0;
      vrf_we_o           = 1'b0;
      vrf_raddr_a_o      = '0;
      vrf_raddr_b_o      = '0;
      vrf_waddr_o        = '0;
      vrf_num_operands_o = '0;
      vrf_lmul_o         = '0;
      vrf_wdata_o        = '0;
      if (busy) begin
         vrf_req_o          = 1'b1;
         vrf_we_o           = we_i[owner_reg];
         vrf_raddr_a_o      = raddr_a_arr[owner_reg];
         vrf_raddr_b_o      = raddr_b_arr[owner_reg];
         vrf_waddr_o        = waddr_arr[owner_reg];
         vrf_num_operands_o = nops_arr[owner_reg];
         vrf_lmul_o         = lmul_arr[owner_reg];
         vrf_wdata_o        = wdata_arr[owner_reg];
      end
   end

   // Read data is broadcast; each consumer qualifies it with its gnt_o bit.
   assign rdata_a_o = vrf_rdata_a_i;
   assign rdata_b_o = vrf_rdata_b_i;
   assign rdata_c_o = vrf_rdata_c_i;

endmodule

// File: tb/tb_vrf_arbiter.sv
module tb_vrf_arbiter;

   localparam int NumReq    = 2;
   localparam int AddrWidth = 5;
   localparam int ELEN      = 32;
   localparam logic [2:0] VLMUL_1 = 3'b000;
   localparam logic [2:0] VLMUL_4 = 3'b010;

   logic                        clk_i = 1'b0;
   logic                        rst_ni = 1'b0;
   logic [NumReq-1:0]           req_i = '0;
   logic [NumReq-1:0]           we_i = '0;
   logic [NumReq*AddrWidth-1:0] raddr_a_i = '0;
   logic [NumReq*AddrWidth-1:0] raddr_b_i = '0;
   logic [NumReq*AddrWidth-1:0] waddr_i = '0;
   logic [NumReq*2-1:0]         num_operands_i = '0;
   logic [NumReq*3-1:0]         lmul_i = '0;
   logic [NumReq*ELEN-1:0]      wdata_i = '0;
   logic [NumReq-1:0]           gnt_o, done_o;
   logic [ELEN-1:0]             rdata_a_o, rdata_b_o, rdata_c_o;
   logic                        vrf_req_o, vrf_we_o;
   logic [AddrWidth-1:0]        vrf_raddr_a_o, vrf_raddr_b_o, vrf_waddr_o;
   logic [1:0]                  vrf_num_operands_o;
   logic [2:0]                  vrf_lmul_o;
   logic [ELEN-1:0]             vrf_wdata_o;
   logic [ELEN-1:0]             vrf_rdata_a_i = '0, vrf_rdata_b_i = '0, vrf_rdata_c_i = '0;
   logic                        vrf_done_i = 1'b0;

   int tests = 0;
   int fails = 0;

   always #5 clk_i = ~clk_i;

   vrf_arbiter #(.NumReq(NumReq), .AddrWidth(AddrWidth), .ELEN(ELEN)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .we_i(we_i),
      .raddr_a_i(raddr_a_i), .raddr_b_i(raddr_b_i), .waddr_i(waddr_i),
      .num_operands_i(num_operands_i), .lmul_i(lmul_i), .wdata_i(wdata_i),
      .gnt_o(gnt_o), .done_o(done_o),
      .rdata_a_o(rdata_a_o), .rdata_b_o(rdata_b_o), .rdata_c_o(rdata_c_o),
      .vrf_req_o(vrf_req_o), .vrf_we_o(vrf_we_o),
      .vrf_raddr_a_o(vrf_raddr_a_o), .vrf_raddr_b_o(vrf_raddr_b_o), .vrf_waddr_o(vrf_waddr_o),
      .vrf_num_operands_o(vrf_num_operands_o), .vrf_lmul_o(vrf_lmul_o), .vrf_wdata_o(vrf_wdata_o),
      .vrf_rdata_a_i(vrf_rdata_a_i), .vrf_rdata_b_i(vrf_rdata_b_i), .vrf_rdata_c_i(vrf_rdata_c_i),
      .vrf_done_i(vrf_done_i)
   );

   task automatic tick();
      @(negedge clk_i);
   endtask

   task automatic set_fields(input int k, input logic we, input logic [4:0] ra, input logic [4:0] rb,
                             input logic [4:0] wa, input logic [1:0] nops, input logic [2:0] lmul,
                             input logic [31:0] wd);
      we_i[k]                = we;
      raddr_a_i[k*5 +: 5]    = ra;
      raddr_b_i[k*5 +: 5]    = rb;
      waddr_i[k*5 +: 5]      = wa;
      num_operands_i[k*2 +: 2] = nops;
      lmul_i[k*3 +: 3]       = lmul;
      wdata_i[k*32 +: 32]    = wd;
   endtask

   task automatic test_reset();
      rst_ni = 1'b0;
      tick();
      tests++; if (gnt_o !== 2'b00) begin fails++; $display("FAIL reset_gnt actual=%b required=00", gnt_o); end
      tests++; if (done_o !== 2'b00) begin fails++; $display("FAIL reset_done actual=%b required=00", done_o); end
      tests++; if (vrf_req_o !== 1'b0) begin fails++; $display("FAIL reset_vrf_req actual=%b required=0", vrf_req_o); end
      tests++; if (vrf_waddr_o !== 5'd0) begin fails++; $display("FAIL reset_vrf_waddr actual=%0d required=0", vrf_waddr_o); end
      rst_ni = 1'b1;
      $display("[TB] test_reset done");
   endtask

   task automatic test_single_op();
      set_fields(0, 1'b0, 5'd1, 5'd2, 5'd3, 2'd2, VLMUL_1, 32'h0);
      req_i = 2'b01;
      tick();
      tests++; if (gnt_o !== 2'b01) begin fails++; $display("FAIL single_gnt actual=%b required=01", gnt_o); end
      tests++; if (vrf_req_o !== 1'b1) begin fails++; $display("FAIL single_vrf_req actual=%b required=1", vrf_req_o); end
      tests++; if (vrf_num_operands_o !== 2'd2) begin fails++; $display("FAIL single_nops actual=%0d required=2", vrf_num_operands_o); end
      tests++; if (vrf_raddr_b_o !== 5'd2) begin fails++; $display("FAIL single_raddr_b actual=%0d required=2", vrf_raddr_b_o); end
      tick(); tick(); tick();
      tests++; if (gnt_o !== 2'b01) begin fails++; $display("FAIL single_gnt_held actual=%b required=01", gnt_o); end
      vrf_done_i = 1'b1;
      req_i = 2'b00;
      #1;
      tests++; if (done_o !== 2'b01) begin fails++; $display("FAIL single_done actual=%b required=01", done_o); end
      tick();
      vrf_done_i = 1'b0;
      #1;
      tests++; if (gnt_o !== 2'b00) begin fails++; $display("FAIL single_gnt_release actual=%b required=00", gnt_o); end
      tests++; if (done_o !== 2'b00) begin fails++; $display("FAIL single_done_clear actual=%b required=00", done_o); end
      tests++; if (vrf_req_o !== 1'b0) begin fails++; $display("FAIL single_vrf_req_low actual=%b required=0", vrf_req_o); end
      $display("[TB] test_single_op done");
   endtask

   task automatic test_round_robin();
      rst_ni = 1'b0;
      tick();
      rst_ni = 1'b1;
      set_fields(0, 1'b0, 5'd10, 5'd11, 5'd12, 2'd1, VLMUL_1, 32'h0);
      set_fields(1, 1'b0, 5'd20, 5'd21, 5'd22, 2'd2, VLMUL_1, 32'h0);
      req_i = 2'b11;
      tick();
      tests++; if (gnt_o !== 2'b01) begin fails++; $display("FAIL rr_first_gnt actual=%b required=01", gnt_o); end
      tests++; if (vrf_raddr_a_o !== 5'd10) begin fails++; $display("FAIL rr_first_raddr actual=%0d required=10", vrf_raddr_a_o); end
      tick();
      tests++; if (done_o !== 2'b00) begin fails++; $display("FAIL rr_nonowner_done actual=%b required=00", done_o); end
      tests++; if (gnt_o !== 2'b01) begin fails++; $display("FAIL rr_nonowner_gnt actual=%b required=01", gnt_o); end
      vrf_done_i = 1'b1;
      req_i = 2'b10;
      #1;
      tests++; if (done_o !== 2'b01) begin fails++; $display("FAIL rr_done0 actual=%b required=01", done_o); end
      tick();
      vrf_done_i = 1'b0;
      #1;
      tests++; if (gnt_o !== 2'b00) begin fails++; $display("FAIL rr_bubble actual=%b required=00", gnt_o); end
      tick();
      tests++; if (gnt_o !== 2'b10) begin fails++; $display("FAIL rr_second_gnt actual=%b required=10", gnt_o); end
      tests++; if (vrf_raddr_a_o !== 5'd20) begin fails++; $display("FAIL rr_second_raddr actual=%0d required=20", vrf_raddr_a_o); end
      tick();
      vrf_done_i = 1'b1;
      req_i = 2'b11;
      #1;
      tests++; if (done_o !== 2'b10) begin fails++; $display("FAIL rr_done1 actual=%b required=10", done_o); end
      tick();
      vrf_done_i = 1'b0;
      tick();
      tests++; if (gnt_o !== 2'b01) begin fails++; $display("FAIL rr_third_gnt actual=%b required=01", gnt_o); end
      vrf_done_i = 1'b1;
      req_i = 2'b00;
      tick();
      vrf_done_i = 1'b0;
      $display("[TB] test_round_robin done");
   endtask

   task automatic test_rr_after_owner1();
      req_i = 2'b10;
      tick();
      tests++; if (gnt_o !== 2'b10) begin fails++; $display("FAIL rr1_gnt actual=%b required=10", gnt_o); end
      vrf_done_i = 1'b1;
      req_i = 2'b00;
      #1;
      tests++; if (done_o !== 2'b10) begin fails++; $display("FAIL rr1_done actual=%b required=10", done_o); end
      tick();
      vrf_done_i = 1'b0;
      tick();
      req_i = 2'b11;
      tick();
      tests++; if (gnt_o !== 2'b01) begin fails++; $display("FAIL rr1_wrap_gnt actual=%b required=01", gnt_o); end
      vrf_done_i = 1'b1;
      req_i = 2'b00;
      #1;
      tests++; if (done_o !== 2'b01) begin fails++; $display("FAIL rr1_wrap_done actual=%b required=01", done_o); end
      tick();
      vrf_done_i = 1'b0;
      $display("[TB] test_rr_after_owner1 done");
   endtask

   task automatic test_back_to_back();
      req_i = 2'b01;
      tick();
      tests++; if (gnt_o !== 2'b01) begin fails++; $display("FAIL b2b_first_gnt actual=%b required=01", gnt_o); end
      vrf_done_i = 1'b1;
      #1;
      tests++; if (done_o !== 2'b01) begin fails++; $display("FAIL b2b_done actual=%b required=01", done_o); end
      tick();
      vrf_done_i = 1'b0;
      #1;
      tests++; if (vrf_req_o !== 1'b0) begin fails++; $display("FAIL b2b_idle_req actual=%b required=0", vrf_req_o); end
      tick();
      tests++; if (gnt_o !== 2'b01) begin fails++; $display("FAIL b2b_second_gnt actual=%b required=01", gnt_o); end
      vrf_done_i = 1'b1;
      req_i = 2'b00;
      tick();
      vrf_done_i = 1'b0;
      $display("[TB] test_back_to_back done");
   endtask

   task automatic test_drop_req();
      req_i = 2'b01;
      tick();
      tests++; if (gnt_o !== 2'b01) begin fails++; $display("FAIL drop_gnt actual=%b required=01", gnt_o); end
      req_i = 2'b00;
      tick();
      tests++; if (gnt_o !== 2'b01) begin fails++; $display("FAIL drop_gnt_held actual=%b required=01", gnt_o); end
      tests++; if (vrf_req_o !== 1'b1) begin fails++; $display("FAIL drop_vrf_req_held actual=%b required=1", vrf_req_o); end
      tick();
      vrf_done_i = 1'b1;
      #1;
      tests++; if (done_o !== 2'b01) begin fails++; $display("FAIL drop_done actual=%b required=01", done_o); end
      tick();
      vrf_done_i = 1'b0;
      #1;
      tests++; if (done_o !== 2'b00) begin fails++; $display("FAIL drop_done_once actual=%b required=00", done_o); end
      tick();
      tests++; if (gnt_o !== 2'b00) begin fails++; $display("FAIL drop_no_regrant actual=%b required=00", gnt_o); end
      $display("[TB] test_drop_req done");
   endtask

   task automatic test_spurious_and_async_reset();
      vrf_done_i = 1'b1;
      #1;
      tests++; if (done_o !== 2'b00) begin fails++; $display("FAIL spurious_done actual=%b required=00", done_o); end
      tick();
      vrf_done_i = 1'b0;
      #1;
      tests++; if (vrf_req_o !== 1'b0) begin fails++; $display("FAIL spurious_state actual=%b required=0", vrf_req_o); end
      req_i = 2'b01;
      tick();
      tests++; if (gnt_o !== 2'b01) begin fails++; $display("FAIL spurious_then_gnt actual=%b required=01", gnt_o); end
      #2;
      rst_ni = 1'b0;
      #1;
      tests++; if (gnt_o !== 2'b00) begin fails++; $display("FAIL areset_gnt actual=%b required=00", gnt_o); end
      tests++; if (vrf_req_o !== 1'b0) begin fails++; $display("FAIL areset_vrf_req actual=%b required=0", vrf_req_o); end
      tick();
      rst_ni = 1'b1;
      req_i = 2'b11;
      tick();
      tests++; if (gnt_o !== 2'b01) begin fails++; $display("FAIL areset_rr_ptr actual=%b required=01", gnt_o); end
      vrf_done_i = 1'b1;
      req_i = 2'b00;
      tick();
      vrf_done_i = 1'b0;
      $display("[TB] test_spurious_and_async_reset done");
   endtask

   task automatic test_lmul4_write();
      set_fields(0, 1'b0, 5'd7, 5'd8, 5'd9, 2'd3, VLMUL_1, 32'h12345678);
      set_fields(1, 1'b1, 5'd1, 5'd2, 5'd5, 2'd3, VLMUL_4, 32'hDEADBEEF);
      vrf_rdata_a_i = 32'hA5A5_0001;
      vrf_rdata_b_i = 32'h5A5A_0002;
      vrf_rdata_c_i = 32'hC3C3_0003;
      req_i = 2'b10;
      tick();
      for (int c = 0; c < 8; c++) begin
         tests++; if (gnt_o !== 2'b10) begin fails++; $display("FAIL lmul4_gnt[%0d] actual=%b required=10", c, gnt_o); end
         tests++; if (vrf_wdata_o !== 32'hDEADBEEF) begin fails++; $display("FAIL lmul4_wdata[%0d] actual=%h required=deadbeef", c, vrf_wdata_o); end
         tests++; if (vrf_waddr_o !== 5'd5) begin fails++; $display("FAIL lmul4_waddr[%0d] actual=%0d required=5", c, vrf_waddr_o); end
         tests++; if (vrf_we_o !== 1'b1) begin fails++; $display("FAIL lmul4_we[%0d] actual=%b required=1", c, vrf_we_o); end
         tests++; if (vrf_lmul_o !== VLMUL_4) begin fails++; $display("FAIL lmul4_lmul[%0d] actual=%b required=010", c, vrf_lmul_o); end
         tick();
      end
      tests++; if (rdata_b_o !== 32'h5A5A_0002) begin fails++; $display("FAIL lmul4_rdata_b actual=%h required=5a5a0002", rdata_b_o); end
      tests++; if (rdata_c_o !== 32'hC3C3_0003) begin fails++; $display("FAIL lmul4_rdata_c actual=%h required=c3c30003", rdata_c_o); end
      vrf_done_i = 1'b1;
      req_i = 2'b00;
      #1;
      tests++; if (done_o !== 2'b10) begin fails++; $display("FAIL lmul4_done actual=%b required=10", done_o); end
      tick();
      vrf_done_i = 1'b0;
      #1;
      tests++; if (vrf_wdata_o !== 32'h0) begin fails++; $display("FAIL lmul4_idle_wdata actual=%h required=00000000", vrf_wdata_o); end
      tests++; if (vrf_we_o !== 1'b0) begin fails++; $display("FAIL lmul4_idle_we actual=%b required=0", vrf_we_o); end
      $display("[TB] test_lmul4_write done");
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_single_op();
      test_round_robin();
      test_rr_after_owner1();
      test_back_to_back();
      test_drop_req();
      test_spurious_and_async_reset();
      test_lmul4_write();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
